// File: rtl/ul_rx_sequencer.sv
// ul_rx_sequencer: uplink receive frame sequencer.
// Runs preamble training with a timeout, then shifts ID and DATA fields
// off ul_in. The fields are sampled mid-bit using a clk_div phase counter.
// The completed {msg_id,msg_data} frame is offered on a valid/ready port.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                receive enable; dropping it aborts a frame before OUTPUT
//   clk_div           bit period minus one, latched when training completes
//   tmo_limit         training timeout in cycles, 0 disables the timeout
//   ul_in             serial uplink line, already synchronised
//   train_start       one-cycle start pulse to the training detector
//   train_done        training detector done (level or pulse)
//   msg_id, msg_data  received fields, MSB first on the line
//   msg_valid         frame available
//   msg_ready         downstream accepts the frame
//   busy              sequencer is not idle
//   err_timeout       one-cycle pulse when training times out
module ul_rx_sequencer #(
    parameter int DIV_WIDTH = 8,
    parameter int ID_BITS   = 8,
    parameter int DATA_BITS = 32,
    parameter int TMO_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic [TMO_WIDTH-1:0] tmo_limit,
    input  logic                 ul_in,
    output logic                 train_start,
    input  logic                 train_done,
    output logic [ID_BITS-1:0]   msg_id,
    output logic [DATA_BITS-1:0] msg_data,
    output logic                 msg_valid,
    input  logic                 msg_ready,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int MAXB = (ID_BITS > DATA_BITS) ? ID_BITS : DATA_BITS;
    localparam int BW   = $clog2(MAXB + 1);

    typedef enum logic [2:0] {
        IDLE,
        TRAIN_START,
        TRAIN_WAIT,
        RX_ID,
        RX_DATA,
        OUTPUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt;
    logic [BW-1:0]        bit_cnt;
    logic [ID_BITS-1:0]   id_sr;
    logic [DATA_BITS-1:0] data_sr;
    logic [TMO_WIDTH-1:0] tmo_cnt;

    logic strobe;
    logic tmo_hit;
    logic id_last;
    logic data_last;
    logic go_rx;
    logic go_tmo;
    logic go_out;

    // Mid-bit sample point of each bit period
    assign strobe    = (cnt == (div_q >> 1));
    assign tmo_hit   = (tmo_limit != '0) &&
                       (tmo_cnt == tmo_limit - 1'b1);
    assign id_last   = (bit_cnt == BW'(ID_BITS - 1));
    assign data_last = (bit_cnt == BW'(DATA_BITS - 1));

    // Abort has priority, then training done, then timeout
    assign go_rx  = (state == TRAIN_WAIT) && en && train_done;
    assign go_tmo = (state == TRAIN_WAIT) && en && !train_done && tmo_hit;
    assign go_out = (state == RX_DATA) && en && strobe && data_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (en) state_nx = TRAIN_START;
            end
            TRAIN_START: begin
                state_nx = en ? TRAIN_WAIT : IDLE;
            end
            TRAIN_WAIT: begin
                if (!en)             state_nx = IDLE;
                else if (train_done) state_nx = RX_ID;
                else if (tmo_hit)    state_nx = IDLE;
            end
            RX_ID: begin
                if (!en)                   state_nx = IDLE;
                else if (strobe && id_last) state_nx = RX_DATA;
            end
            RX_DATA: begin
                if (!en)                     state_nx = IDLE;
                else if (strobe && data_last) state_nx = OUTPUT;
            end
            OUTPUT: begin
                if (msg_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        train_start = 1'b0;
        msg_valid   = 1'b0;
        busy        = 1'b1;
        unique case (state)
            IDLE:        busy        = 1'b0;
            TRAIN_START: train_start = 1'b1;
            OUTPUT:      msg_valid   = 1'b1;
            default:     ;
        endcase
    end

    // Timeout counter and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= go_tmo;
            if (state == TRAIN_START) begin
                tmo_cnt <= '0;
            end else if (state == TRAIN_WAIT && tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Bit timing and field shifters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            id_sr   <= '0;
            data_sr <= '0;
        end else if (go_rx) begin
            div_q   <= clk_div;
            cnt     <= '0;
            bit_cnt <= '0;
            id_sr   <= '0;
            data_sr <= '0;
        end else if (state == RX_ID || state == RX_DATA) begin
            // Free-running across the ID/DATA boundary
            cnt <= (cnt == div_q) ? '0 : cnt + 1'b1;
            if (strobe) begin
                if (state == RX_ID) begin
                    id_sr   <= {id_sr[ID_BITS-2:0], ul_in};
                    bit_cnt <= id_last ? '0 : bit_cnt + 1'b1;
                end else begin
                    data_sr <= {data_sr[DATA_BITS-2:0], ul_in};
                    bit_cnt <= data_last ? '0 : bit_cnt + 1'b1;
                end
            end
        end
    end

    // Output frame; keeps its value after the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_id   <= '0;
            msg_data <= '0;
        end else if (go_out) begin
            msg_id   <= id_sr;
            msg_data <= {data_sr[DATA_BITS-2:0], ul_in};
        end
    end

endmodule

// File: tb/tb_ul_rx_sequencer.sv
// tb_ul_rx_sequencer: directed bench for ul_rx_sequencer.
// Expected frames go to a queue and are compared at each handshake.
module tb_ul_rx_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  clk_div = '0;
    logic [15:0] tmo_limit = '0;
    logic        ul_in = 1'b0;
    logic        train_start;
    logic        train_done = 1'b0;
    logic [7:0]  msg_id;
    logic [31:0] msg_data;
    logic        msg_valid;
    logic        msg_ready = 1'b0;
    logic        busy;
    logic        err_timeout;

    int compared = 0;
    int mismatched = 0;
    int err_cnt = 0;
    int frame_cnt = 0;

    logic [39:0] exp_q[$];
    logic [39:0] mon_exp;
    logic [39:0] held = '0;
    logic        stall = 1'b0;

    ul_rx_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clk_div    (clk_div),
        .tmo_limit  (tmo_limit),
        .ul_in      (ul_in),
        .train_start(train_start),
        .train_done (train_done),
        .msg_id     (msg_id),
        .msg_data   (msg_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ts(input string tag);
        int n = 0;
        while (train_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, train_start, 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (msg_valid !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk(tag, msg_valid, 1'b1);
    endtask

    // Entered in the train_start cycle. train_done is raised wait_n
    // cycles later; each bit is then held for div+1 cycles starting
    // at RX_ID entry. abort_at >= 0 drops en at the start of that bit.
    task automatic run_frame(input logic [7:0] id, input logic [31:0] data,
                             input int div, input int wait_n,
                             input int abort_at);
        logic [39:0] bits;
        bits = {id, data};
        if (abort_at < 0) exp_q.push_back(bits);
        clk_div = div[7:0];
        repeat (wait_n) step();
        train_done = 1'b1;
        step();
        train_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == abort_at) begin
                en = 1'b0;
                step();
                return;
            end
            ul_in = bits[39-k];
            repeat (div + 1) step();
        end
    endtask

    // Handshake scoreboard, hold-stability and error pulse monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", msg_valid, 1'b1);
                chk("hold_frame", {msg_id, msg_data}, held);
            end
            if (err_timeout) err_cnt++;
            if (msg_valid && msg_ready) begin
                frame_cnt++;
                chk("frame_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("frame_data", {msg_id, msg_data}, mon_exp);
                end
            end
            stall = msg_valid && !msg_ready;
            held  = {msg_id, msg_data};
        end
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_train_start", train_start, 1'b0);
        chk("rst_msg_id", msg_id, 8'h00);
        chk("rst_msg_data", msg_data, 32'h0);
        chk("rst_msg_valid", msg_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        rst_n = 1'b1;
        step();

        // Nominal frame, 4 clk/bit, then back-to-back restart
        en = 1'b1;
        wait_ts("nom_train_start");
        chk("nom_busy", busy, 1'b1);
        run_frame(8'hA5, 32'hDEADBEEF, 3, 10, -1);
        wait_valid("nom_valid");
        msg_ready = 1'b1;
        step();
        msg_ready = 1'b0;
        chk("nom_valid_drop", msg_valid, 1'b0);
        chk("nom_id_retain", msg_id, 8'hA5);
        chk("nom_data_retain", msg_data, 32'hDEADBEEF);
        chk("b2b_gap", train_start, 1'b0);
        step();
        chk("b2b_train_start", train_start, 1'b1);
        en = 1'b0;
        step();
        chk("ts_abort_idle", busy, 1'b0);
        chk("nom_frames", frame_cnt, 1);

        // Training timeout: limit waiting cycles, then the pulse
        tmo_limit = 16'd20;
        en = 1'b1;
        wait_ts("tmo_train_start");
        n = 0;
        while (err_timeout !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("tmo_latency", n, 21);
        chk("tmo_busy_drop", busy, 1'b0);
        chk("tmo_no_valid", msg_valid, 1'b0);
        en = 1'b0;
        tmo_limit = '0;
        repeat (5) step();
        chk("tmo_pulse_once", err_cnt, 1);
        chk("tmo_no_frame", frame_cnt, 1);

        // Backpressure with en dropped during the stall
        en = 1'b1;
        wait_ts("bp_train_start");
        run_frame(8'h5A, 32'h12345678, 2, 3, -1);
        wait_valid("bp_valid");
        for (int i = 0; i < 50; i++) begin
            if (i == 10) en = 1'b0;
            step();
        end
        chk("bp_valid_held", msg_valid, 1'b1);
        chk("bp_frame_held", {msg_id, msg_data}, {8'h5A, 32'h12345678});
        msg_ready = 1'b1;
        step();
        msg_ready = 1'b0;
        chk("bp_valid_drop", msg_valid, 1'b0);
        chk("bp_idle", busy, 1'b0);

        // Abort at data bit 12, then a clean frame
        en = 1'b1;
        wait_ts("ab_train_start");
        run_frame(8'h11, 32'hFFFF0000, 3, 4, 20);
        chk("ab_idle", busy, 1'b0);
        chk("ab_no_valid", msg_valid, 1'b0);
        repeat (3) step();
        chk("ab_no_frame", frame_cnt, 2);
        en = 1'b1;
        wait_ts("ab2_train_start");
        run_frame(8'h3C, 32'h00000000, 3, 4, -1);
        wait_valid("ab2_valid");
        msg_ready = 1'b1;
        en = 1'b0;
        step();
        msg_ready = 1'b0;
        chk("ab2_frames", frame_cnt, 3);

        // clk_div=0 with ready already high: one-cycle transfer
        msg_ready = 1'b1;
        en = 1'b1;
        wait_ts("d0_train_start");
        run_frame(8'hFF, 32'h00000001, 0, 3, -1);
        chk("d0_valid", msg_valid, 1'b1);
        step();
        chk("d0_valid_drop", msg_valid, 1'b0);

        // train_done in the same cycle as timeout expiry
        tmo_limit = 16'd5;
        wait_ts("same_train_start");
        run_frame(8'h81, 32'hCAFEF00D, 1, 5, -1);
        en = 1'b0;
        tmo_limit = '0;
        msg_ready = 1'b0;
        repeat (4) step();
        chk("same_no_err", err_cnt, 1);
        chk("same_frames", frame_cnt, 5);
        chk("same_id", msg_id, 8'h81);

        // Async reset in the middle of RX_ID
        en = 1'b1;
        wait_ts("rs_train_start");
        clk_div = 8'd3;
        repeat (2) step();
        train_done = 1'b1;
        step();
        train_done = 1'b0;
        repeat (6) step();
        chk("rs_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_busy", busy, 1'b0);
        chk("rs_msg_id", msg_id, 8'h00);
        chk("rs_msg_data", msg_data, 32'h0);
        chk("rs_valid", msg_valid, 1'b0);
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        en = 1'b1;
        wait_ts("rs_restart");
        en = 1'b0;
        repeat (3) step();
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_frames", frame_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
